fp_div_seq: RTL and testbench
=============================

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  operands and r_mode valid this cycle.
REQ-004 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-005 fp_X  input  32  IEEE-754 single dividend.
REQ-006 fp_Y  input  32  IEEE-754 single divisor.
REQ-007 r_mode  input  3  rounding: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
REQ-008 out_valid  output  1  fp_Z/ovrf/udrf valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 fp_Z  output  32  quotient.
REQ-011 ovrf  output  1  overflow occurred.
REQ-012 udrf  output  1  underflow occurred.

Function
REQ-013 Accept on rising edge with in_valid && in_ready; fp_X, fp_Y, r_mode registered; later input changes ignored.
REQ-014 States IDLE -> DIV -> ROUND -> DONE -> IDLE; DONE -> IDLE only on out_valid && out_ready.
REQ-015 DIV: radix-2 restoring division of {1,frc_X} by {1,frc_Y}, one quotient bit per cycle, 26 cycles (1 integer, 23 fraction, guard, round); sticky = OR of final remainder.
REQ-016 Normal-operand latency fixed: out_valid rises exactly 28 edges after the accepting edge (26 DIV, 1 ROUND, 1 register).
REQ-017 If quotient integer bit is 0, shift left one and decrement exponent before rounding.
REQ-018 Exponent computed in 10-bit signed: exp_Z = eX - eY + 127 (minus normalization adjust, plus rounding carry).
REQ-019 Sign = fp_X[31] ^ fp_Y[31] for every result, including zero and infinity.
REQ-020 Rounding per REQ-007 using guard/round/sticky; RDN increments magnitude only if sign=1 and inexact, RUP only if sign=0 and inexact; mantissa carry-out renormalizes and increments exponent.
REQ-021 Final exp >= 255: ovrf=1, fp_Z = signed infinity.
REQ-022 Final exp <= 0: udrf=1, fp_Z = signed zero (flush, no subnormal output).
REQ-023 Subnormal operands (exponent 0) treated as zero.
REQ-024 Specials: X or Y NaN, 0/0, inf/inf -> 32'h7FC00000; finite/0 -> signed inf; X inf, Y finite -> signed inf; X 0 or Y inf -> signed zero; ovrf=udrf=0 for all specials.
REQ-025 While out_valid && !out_ready, fp_Z, ovrf, udrf held stable.
REQ-026 in_ready=0 and in_valid ignored in DIV, ROUND, DONE.

Reset
REQ-027 rst asserted: state IDLE, in_ready=1, out_valid=0, fp_Z=0, ovrf=0, udrf=0, datapath registers cleared, next edge.
REQ-028 rst during DIV/ROUND/DONE aborts operation; no result ever produced for it.
REQ-029 rst dominates simultaneous in_valid or out_ready.

Configuration
REQ-030 Macro FP_DIV_EARLY_OUT_EN defined: special operands (REQ-023/024) bypass DIV/ROUND, out_valid rises 1 edge after accept.
REQ-031 Macro undefined: special operands use full 28-cycle latency; result values identical.

Structure
REQ-032 Package fp_pkg holds state enum, r_mode constants, BIAS=127, QNAN=32'h7FC00000, INF/ZERO field constants.
REQ-033 Rounding/normalization in sub-module fp_div_round (combinational, used in ROUND state).

Verification
REQ-034 fp_X=40C00000 (6.0), fp_Y=40000000, RNE -> fp_Z=40400000, out_valid 28 edges after accept, flags 0.
REQ-035 fp_X=3F800000, fp_Y=40400000: RNE -> 3EAAAAAB; RTZ -> 3EAAAAAA; RUP -> 3EAAAAAB; RDN with fp_X=BF800000 -> BEAAAAAB.
REQ-036 Specials: 3F800000/00000000 -> 7F800000; 00000000/00000000 -> 7FC00000; BF800000/7F800000 -> 80000000; latency 1 with FP_DIV_EARLY_OUT_EN, 28 without.
REQ-037 7F7FFFFF/00800000 -> ovrf=1, fp_Z=7F800000; 00800000/7F7FFFFF -> udrf=1, fp_Z=00000000.
REQ-038 out_ready held 0 for 5 cycles after out_valid -> fp_Z stable, in_ready=0; new operand with in_valid during hold not accepted.
REQ-039 rst pulse at DIV cycle 10 -> out_valid stays 0, in_ready=1 next edge; next operation produces correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Holds the FSM state encoding, rounding-mode codes and special-operand decode.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_e;

  localparam logic [2:0]  RM_RNE   = 3'b000;
  localparam logic [2:0]  RM_RTZ   = 3'b001;
  localparam logic [2:0]  RM_RDN   = 3'b010;
  localparam logic [2:0]  RM_RUP   = 3'b011;
  localparam logic [2:0]  RM_RMM   = 3'b100;
  localparam logic [9:0]  BIAS     = 10'd127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF  = 8'hFF;
  localparam logic [7:0]  EXP_ZERO = 8'h00;

  typedef struct packed {
    logic        hit;
    logic [31:0] z;
  } special_t;

  // Subnormal inputs count as zero, so only the exponent field decides "zero".
  function automatic special_t fp_special(input logic [31:0] x, input logic [31:0] y);
    special_t res;
    logic     x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, sgn;
    x_zero = (x[30:23] == EXP_ZERO);
    y_zero = (y[30:23] == EXP_ZERO);
    x_inf  = (x[30:23] == EXP_INF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == EXP_INF) && (y[22:0] == 23'd0);
    x_nan  = (x[30:23] == EXP_INF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == EXP_INF) && (y[22:0] != 23'd0);
    sgn    = x[31] ^ y[31];
    res.hit = 1'b1;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      res.z = QNAN;
    end else if (y_zero || x_inf) begin
      res.z = {sgn, EXP_INF, 23'd0};
    end else if (x_zero || y_inf) begin
      res.z = {sgn, 31'd0};
    end else begin
      res.hit = 1'b0;
      res.z   = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational normalize/round/pack stage for the divider quotient.
// Takes the 26-bit raw quotient (1 int, 23 frac, guard, round) plus sticky.
module fp_div_round
  import fp_pkg::*;
(
  input  logic [25:0] quo,
  input  logic        sticky,
  input  logic [7:0]  exp_x,
  input  logic [7:0]  exp_y,
  input  logic        sign,
  input  logic [2:0]  mode,
  output logic [31:0] z,
  output logic        ovrf,
  output logic        udrf
);

  logic [23:0]       mant;
  logic              g, r, inexact, inc;
  logic [24:0]       sum;
  logic signed [9:0] e;

  always_comb begin
    // A quotient below 1.0 has its leading one at bit 24; use one more bit.
    if (quo[25]) begin
      mant = quo[25:2];
      g    = quo[1];
      r    = quo[0];
    end else begin
      mant = quo[24:1];
      g    = quo[0];
      r    = 1'b0;
    end
    inexact = g | r | sticky;
    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (r | sticky | mant[0]);
    endcase
    sum = {1'b0, mant} + {24'd0, inc};
    e   = {2'b00, exp_x} - {2'b00, exp_y} + BIAS - {9'd0, ~quo[25]} + {9'd0, sum[24]};
    z    = {sign, e[7:0], (sum[24] ? sum[23:1] : sum[22:0])};
    ovrf = 1'b0;
    udrf = 1'b0;
    if (e >= 10'sd255) begin
      ovrf = 1'b1;
      z    = {sign, EXP_INF, 23'd0};
    end else if (e <= 10'sd0) begin
      udrf = 1'b1;
      z    = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider: radix-2 restoring, 26 quotient bits, 28-edge latency.
// FP_DIV_EARLY_OUT_EN: special operands skip DIV/ROUND and finish one edge after accept.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output fp_state_e   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, and outputs stay frozen while out_valid && !out_ready.
  fp_state_e   state;
  logic [31:0] x_q, y_q;
  logic [2:0]  mode_q;
  logic [24:0] rem, rem_diff, rem_sel;
  logic [23:0] dsr;
  logic [25:0] quo;
  logic [4:0]  cnt;
  logic        ge;
  special_t    sp_q;
  logic [31:0] rnd_z;
  logic        rnd_ovrf, rnd_udrf;
`ifdef FP_DIV_EARLY_OUT_EN
  special_t    sp_in;
  assign sp_in = fp_special(fp_X, fp_Y);
`endif

  assign sp_q      = fp_special(x_q, y_q);
  assign ge        = (rem >= {1'b0, dsr});
  assign rem_diff  = rem - {1'b0, dsr};
  assign rem_sel   = ge ? rem_diff : rem;
  assign dbg_state = state;

  fp_div_round u_round (
    .quo    (quo),
    .sticky (|rem),
    .exp_x  (x_q[30:23]),
    .exp_y  (y_q[30:23]),
    .sign   (x_q[31] ^ y_q[31]),
    .mode   (mode_q),
    .z      (rnd_z),
    .ovrf   (rnd_ovrf),
    .udrf   (rnd_udrf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      fp_Z      <= 32'd0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      mode_q    <= 3'd0;
      rem       <= 25'd0;
      dsr       <= 24'd0;
      quo       <= 26'd0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          x_q      <= fp_X;
          y_q      <= fp_Y;
          mode_q   <= r_mode;
          rem      <= {2'b01, fp_X[22:0]};
          dsr      <= {1'b1, fp_Y[22:0]};
          quo      <= 26'd0;
          cnt      <= 5'd0;
          in_ready <= 1'b0;
`ifdef FP_DIV_EARLY_OUT_EN
          if (sp_in.hit) begin
            fp_Z  <= sp_in.z;
            ovrf  <= 1'b0;
            udrf  <= 1'b0;
            state <= ST_DONE;
          end else begin
            state <= ST_DIV;
          end
`else
          state    <= ST_DIV;
`endif
        end
        ST_DIV: begin
          quo <= {quo[24:0], ge};
          rem <= rem_sel << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (sp_q.hit) begin
            fp_Z <= sp_q.z;
            ovrf <= 1'b0;
            udrf <= 1'b0;
          end else begin
            fp_Z <= rnd_z;
            ovrf <= rnd_ovrf;
            udrf <= rnd_udrf;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE edge raises out_valid; the result registers are already loaded.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: randomized and directed divisions checked against a wide-integer model.
// Respects FP_DIV_EARLY_OUT_EN when predicting latency of special operands.
module tb_fp_div_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovrf, udrf;
  logic [31:0] fp_X, fp_Y, fp_Z;
  logic [2:0]  r_mode;
  fp_state_e   dbg_state;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hold_left = 0;
  logic [33:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: exact quotient scaled by 2^40 with integer division, then round by remainder size.
  function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    int ex, ey, e, sh;
    logic sg, up, inexact, tie, above;
    longint unsigned mx, my, q, rem, low, half, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sg = x[31] ^ y[31];
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 0 && ey == 0) || (ex == 255 && ey == 255)) return {32'h7FC00000, 2'b00};
    if (ey == 0 || ex == 255) return {sg, 8'hFF, 23'd0, 2'b00};
    if (ex == 0 || ey == 255) return {sg, 31'd0, 2'b00};
    mx  = 64'(x[22:0]) | (64'd1 << 23);
    my  = 64'(y[22:0]) | (64'd1 << 23);
    q   = (mx << 40) / my;
    rem = (mx << 40) % my;
    e   = ex - ey + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    mant    = q >> sh;
    low     = q & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (low != 0) || (rem != 0);
    tie     = (low == half) && (rem == 0);
    above   = (low > half) || ((low == half) && (rem != 0));
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sg && inexact;
      3'd3:    up = !sg && inexact;
      3'd4:    up = (low >= half);
      default: up = above || (tie && mant[0]);
    endcase
    mant = mant + 64'(up);
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0, 2'b10};
    if (e <= 0)   return {sg, 31'd0, 2'b01};
    return {sg, 8'(e), 23'(mant), 2'b00};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) v[30:23] = 8'(254 - $urandom_range(0, 3));
    else if (k == 3) v[30:23] = 8'($urandom_range(1, 4));
    else             v[30:23] = 8'($urandom_range(100, 154));
    if ((k == 1 || k == 5) && $urandom_range(0, 1) == 1) v[22:0] = 23'd0;
    return v;
  endfunction

  // driver: called at a falling edge, returns at the falling edge after the accepting edge
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    int n = 0;
    fp_X = x;
    fp_Y = y;
    r_mode = rm;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(ref_div(x, y, rm));
`ifdef FP_DIV_EARLY_OUT_EN
    lat_q.push_back(is_special(x, y) ? 1 : 28);
`else
    lat_q.push_back(28);
`endif
    acc_q.push_back(cyc);
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
    fp_X = $urandom;
    fp_Y = $urandom;
    r_mode = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  // scoreboard monitor: owns out_ready, pops an expectation on each new result
  initial begin
    logic        pending;
    logic [33:0] held, e;
    int          el, acc;
    pending = 1'b0;
    held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else if (out_valid) begin
        check("in_ready_while_valid", 64'(in_ready), 64'd0);
        if (!pending) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=no_output", fp_Z);
          end else begin
            e   = exp_q.pop_front();
            el  = lat_q.pop_front();
            acc = acc_q.pop_front();
            check("result", 64'({fp_Z, ovrf, udrf}), 64'(e));
            check("latency", 64'(cyc - acc), 64'(el));
          end
          held = {fp_Z, ovrf, udrf};
        end else begin
          check("hold_stable", 64'({fp_Z, ovrf, udrf}), 64'(held));
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        pending = !out_ready;
      end else begin
        pending = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int n;
    logic [31:0] dir_x [16] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                32'hBF800000, 32'h3F800000, 32'h00000000, 32'hBF800000,
                                32'h7F7FFFFF, 32'h00800000, 32'h7FC00001, 32'h7F800000,
                                32'hFF800000, 32'h3F800000, 32'h3FC00000, 32'h00012345};
    logic [31:0] dir_y [16] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000,
                                32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000,
                                32'h00800000, 32'h7F7FFFFF, 32'h3F800000, 32'hFF800000,
                                32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000};
    logic [2:0]  dir_m [16] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0,
                                3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd7, 3'd0};
    rst = 1'b1;
    in_valid = 1'b0;
    fp_X = 32'd0;
    fp_Y = 32'd0;
    r_mode = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_fp_z", 64'(fp_Z), 64'd0);
    check("reset_flags", 64'({ovrf, udrf}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors, including specials, overflow, underflow and subnormal-as-zero
    for (int i = 0; i < 16; i++) issue(dir_x[i], dir_y[i], dir_m[i]);
    drain();

    // backpressure hold with a competing operand offered during the hold
    hold_left = 5;
    issue(32'h40C00000, 32'h40000000, 3'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    fp_X = 32'h40800000;
    fp_Y = 32'h3F800000;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (35) @(negedge clk);

    // reset mid-division aborts the operation
    issue(32'h40490FDB, 32'h402DF854, 3'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_fp_z", 64'(fp_Z), 64'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    repeat (40) @(negedge clk);
    issue(32'h3F800000, 32'h40400000, 3'd0);
    drain();

    // randomized operands and modes
    for (int i = 0; i < 150; i++) begin
      issue(rand_fp(), rand_fp(), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    repeat (40) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
